uart_tx_64: RTL and testbench

//  Transmit-side counterpart of the 64-bit UART receive path. Accepts one 64-bit word per

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_byte.sv | 118 +++++++++++
 rtl/uart_tx_64.sv | 92 +++++++++
 tb/tb_uart_tx_64.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 64-bit UART transmit path: FSM encodings, frame geometry
// and the baud-divider helper.
package uart_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int DATA_BITS      = 8;

  // Per-byte frame engine states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  // Word-level sequencer states.
  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_DONE
  } word_state_e;

  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART frame engine (start, 8 data bits LSB first, optional even parity, stop).
// Parity bit is present when UART_TX_PARITY_EN is defined; the default build is 8N1.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic       byte_ready_o,
  output logic       txd_o,
  output logic       frame_end_o
);

  localparam int CNT_W = $clog2(BAUD_DIV);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             txd_q, txd_d;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    bit_end    = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));
    baud_cnt_d = (state_q == S_IDLE || bit_end) ? '0 : baud_cnt_q + 1'b1;

    frame_end_o  = (state_q == S_STOP) && bit_end;
    // Accepting on the last stop cycle lets back-to-back bytes leave no idle gap.
    byte_ready_o = (state_q == S_IDLE) || frame_end_o;

    case (state_q)
      S_IDLE: ;
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          data_d = {1'b0, data_q[7:1]};
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP:  if (bit_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (byte_valid_i && byte_ready_o) begin
      state_d   = S_START;
      bit_cnt_d = '0;
      data_d    = byte_i;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^byte_i;
`endif
    end

    // The line level is registered from the next state so the pin never glitches.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = data_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign txd_o = txd_q;

endmodule

// File: rtl/uart_tx_64.sv
// 64-bit word UART transmitter: one word per valid/ready handshake, sent MSB byte first.
// Define UART_TX_PARITY_EN for 8E1 frames (must match the receive side).
module uart_tx_64
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_64,
  input  logic        data_64_valid,
  output logic        data_64_ready,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_64: BAUD_DIV = CLK_FREQ/BAUD_RATE must be at least 2");
  end

  word_state_e state_q, state_d;
  logic [63:0] shift_q, shift_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        frame_end;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    byte_valid = 1'b0;
    byte_data  = shift_q[63:56];

    case (state_q)
      W_IDLE: begin
        // Byte 0 goes straight from the input so its start bit follows acceptance.
        byte_valid = data_64_valid;
        byte_data  = data_64[63:56];
        if (data_64_valid) begin
          state_d    = W_SEND;
          shift_d    = {data_64[55:0], 8'h00};
          byte_cnt_d = '0;
        end
      end
      W_SEND: begin
        byte_valid = (byte_cnt_q != 3'(BYTES_PER_WORD - 1));
        if (byte_valid && byte_ready) begin
          shift_d    = {shift_q[55:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 3'd1;
        end
        if (frame_end && byte_cnt_q == 3'(BYTES_PER_WORD - 1)) state_d = W_DONE;
      end
      W_DONE:  state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= W_IDLE;
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_byte (
    .clk         (clk),
    .rst         (rst),
    .byte_i      (byte_data),
    .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready),
    .txd_o       (uart_txd),
    .frame_end_o (frame_end)
  );

  assign data_64_ready = (state_q == W_IDLE);
  assign tx_busy       = (state_q != W_IDLE);
  assign tx_done       = (state_q == W_DONE);

endmodule

// File: tb/tb_uart_tx_64.sv
// Self-checking bench for uart_tx_64: line waveform compared cycle by cycle against a
// frame model, plus a mid-bit sampling decoder for loopback.
module tb_uart_tx_64;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int BAUD_DIV  = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int WAIT_LIMIT = 4 * FRAME_BITS * BAUD_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_64 = '0;
  logic        data_64_valid = 1'b0;
  logic        data_64_ready;
  logic        uart_txd;
  logic        tx_busy;
  logic        tx_done;

  int errors = 0;
  int checks = 0;
  bit exp_bits[$];

  uart_tx_64 #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_64      (data_64),
    .data_64_valid(data_64_valid),
    .data_64_ready(data_64_ready),
    .uart_txd     (uart_txd),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference line image of one word: one entry per bit period.
  function automatic void load_word(input logic [63:0] w);
    logic [7:0] b;
    exp_bits.delete();
    for (int i = 0; i < 8; i++) begin
      b = w[63 - 8*i -: 8];
      exp_bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) exp_bits.push_back(b[j]);
`ifdef UART_TX_PARITY_EN
      exp_bits.push_back(^b);
`endif
      exp_bits.push_back(1'b1);
    end
  endfunction

  // Status vector {busy, ready, done}.
  function automatic logic [2:0] status();
    return {tx_busy, data_64_ready, tx_done};
  endfunction

  task automatic run_word(input logic [63:0] w, input bit keep_valid, input logic [63:0] next_w);
    load_word(w);
    data_64       = w;
    data_64_valid = 1'b1;
    check("ready_before_accept", 64'(data_64_ready), 64'd1);
    tick();
    if (keep_valid) data_64 = next_w;
    else begin
      data_64_valid = 1'b0;
      data_64       = {$urandom, $urandom};
    end
    foreach (exp_bits[k]) begin
      for (int c = 0; c < BAUD_DIV; c++) begin
        check("line_bit", 64'(uart_txd), 64'(exp_bits[k]));
        check("status_busy", 64'(status()), 64'(3'b100));
        tick();
      end
    end
    check("done_cycle_status", 64'(status()), 64'(3'b101));
    check("done_cycle_line", 64'(uart_txd), 64'd1);
    tick();
    check("idle_after_done", 64'(status()), 64'(3'b010));
    check("idle_line", 64'(uart_txd), 64'd1);
  endtask

  // Independent receiver: find start edge, sample each bit at its centre.
  task automatic rx_decode(output logic [63:0] w_out);
    logic [7:0] b;
    int waited;
    w_out = '0;
    for (int i = 0; i < 8; i++) begin
      waited = 0;
      while (uart_txd !== 1'b0 && waited < WAIT_LIMIT) begin
        tick();
        waited++;
      end
      check("rx_start_found", 64'(waited < WAIT_LIMIT), 64'd1);
      repeat (BAUD_DIV / 2) tick();
      check("rx_start_mid", 64'(uart_txd), 64'd0);
      for (int j = 0; j < 8; j++) begin
        repeat (BAUD_DIV) tick();
        b[j] = uart_txd;
      end
`ifdef UART_TX_PARITY_EN
      repeat (BAUD_DIV) tick();
      check("rx_parity", 64'(uart_txd), 64'(^b));
`endif
      repeat (BAUD_DIV) tick();
      check("rx_stop", 64'(uart_txd), 64'd1);
      w_out = {w_out[55:0], b};
    end
  endtask

  initial begin : main
    logic [63:0] got;
    logic [63:0] w_a, w_b;
    int waited;

    // Reset held three cycles.
    repeat (3) tick();
    rst = 1'b0;
    check("reset_line", 64'(uart_txd), 64'd1);
    check("reset_status", 64'(status()), 64'(3'b010));
    tick();

    // Directed word, then parity-sensitive bytes 01/03.
    run_word(64'h0123_4567_89AB_CDEF, 1'b0, '0);
    run_word(64'h0103_0000_FFFF_8001, 1'b0, '0);

    // Valid held with a second word during transmission.
    w_a = {$urandom, $urandom};
    w_b = {$urandom, $urandom};
    run_word(w_a, 1'b1, w_b);
    run_word(w_b, 1'b0, '0);

    // Reset during byte 3 data bits.
    load_word(64'hA5C3_5A3C_96E1_7F08);
    data_64       = 64'hA5C3_5A3C_96E1_7F08;
    data_64_valid = 1'b1;
    tick();
    data_64_valid = 1'b0;
    repeat (345) tick();
    check("pre_reset_line", 64'(uart_txd), 64'(exp_bits[34]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_mid_line", 64'(uart_txd), 64'd1);
    check("reset_mid_status", 64'(status()), 64'(3'b010));
    for (int c = 0; c < 4 * BAUD_DIV; c++) begin
      check("quiet_after_reset", 64'({uart_txd, status()}), 64'(4'b1010));
      tick();
    end
    run_word(64'hFFFF_0000_FFFF_0000, 1'b0, '0);

    // Randomized words against the frame model.
    for (int n = 0; n < 3; n++) run_word({$urandom, $urandom}, 1'b0, '0);

    // Loopback through the sampling decoder.
    data_64       = 64'hDEAD_BEEF_CAFE_F00D;
    data_64_valid = 1'b1;
    tick();
    data_64_valid = 1'b0;
    rx_decode(got);
    check("loopback_word", got, 64'hDEAD_BEEF_CAFE_F00D);
    waited = 0;
    while (tx_done !== 1'b1 && waited < WAIT_LIMIT) begin
      tick();
      waited++;
    end
    check("loopback_done_seen", 64'(waited < WAIT_LIMIT), 64'd1);
    tick();
    check("loopback_idle", 64'(status()), 64'(3'b010));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
